// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory read, small instruction FIFO, valid/ready output.
// Define FETCH_STATS_EN to add saturating fetch/stall counters (o_fetch_cnt, o_stall_cnt).
module instr_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_pc_in,
    input  logic              i_pc_valid,
    output logic              o_pc_take,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_ins_out,
    output logic [ADDR_W-1:0] o_ins_pc,
    output logic              o_ins_valid,
    input  logic              i_ins_ready,
`ifdef FETCH_STATS_EN
    output logic [15:0]       o_fetch_cnt,
    output logic [15:0]       o_stall_cnt,
`endif
    output logic [2:0]        o_out_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        r_state;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [PW:0]       r_count;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];

    logic w_push, w_pop;

    // Only one read in flight, so checking space at issue guarantees the push fits.
    assign o_pc_take   = i_rst & (r_state == S_IDLE) & i_pc_valid & (r_count < FULL) & ~i_flush;
    assign w_push      = (r_state == S_REQ) & i_mem_ack & ~i_flush;
    assign o_ins_valid = (r_count != '0);
    assign w_pop       = o_ins_valid & i_ins_ready & ~i_flush;

    assign o_ins_out   = o_ins_valid ? r_data[r_rptr] : '0;
    assign o_ins_pc    = o_ins_valid ? r_pc[r_rptr]   : '0;
    assign o_out_state = o_ins_out[2:0];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            o_mem_req  <= 1'b0;
            o_mem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (o_pc_take) begin
                    o_mem_req  <= 1'b1;
                    o_mem_addr <= i_pc_in;
                    r_state    <= S_REQ;
                end
                // A flush never withdraws the request; the late data is simply dropped.
                S_REQ: if (i_mem_ack) begin
                    o_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end else if (i_flush) begin
                    r_state <= S_DROP;
                end
                S_DROP: if (i_mem_ack) begin
                    o_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    o_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_data[r_wptr] <= i_mem_rdata;
            r_pc[r_wptr]   <= o_mem_addr;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_fetch_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (w_push && o_fetch_cnt != 16'hFFFF)
                o_fetch_cnt <= o_fetch_cnt + 16'd1;
            if (i_ins_ready && !o_ins_valid && o_stall_cnt != 16'hFFFF)
                o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, then scoreboarded multi-cycle sequences.
module tb_instr_fetch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          pc_valid, pc_take, flush;
    logic          mem_req, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, ins_out;
    logic [AW-1:0] ins_pc;
    logic          ins_valid, ins_ready;
    logic [2:0]    out_state;
`ifdef FETCH_STATS_EN
    logic [15:0]   fetch_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_pc_in(pc_in), .i_pc_valid(pc_valid),
        .o_pc_take(pc_take), .i_flush(flush), .o_mem_req(mem_req),
        .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_ins_out(ins_out), .o_ins_pc(ins_pc), .o_ins_valid(ins_valid),
        .i_ins_ready(ins_ready),
`ifdef FETCH_STATS_EN
        .o_fetch_cnt(fetch_cnt), .o_stall_cnt(stall_cnt),
`endif
        .o_out_state(out_state)
    );

    typedef struct packed { logic [DW-1:0] ins; logic [AW-1:0] pc; } ent_t;
    typedef struct {
        logic pv; logic [AW-1:0] pc; logic ack; logic [DW-1:0] rd; logic rdy;
        logic e_take; logic e_req; logic [AW-1:0] e_addr; logic e_val;
        logic [DW-1:0] e_ins; logic [AW-1:0] e_pc; logic [2:0] e_st;
    } vec_t;

    int checks = 0, errors = 0;
    ent_t sbq[$];
    bit m_inflight, m_drop, took, auto_ack;
    logic [AW-1:0] m_addr, last_pop_pc;
    int m_wait, ack_lat, take_cnt, req_cyc, pop_cnt, exp_fetch, exp_stall;
    vec_t tv[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_f(input logic [AW-1:0] a);
        return a * 32'h9E3779B1 + 32'h1;
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_inflight = 0; m_drop = 0; m_wait = 0;
        exp_fetch = 0; exp_stall = 0;
    endtask

    // One clock: compare at negedge against the model, advance the model, drive after posedge.
    task automatic tick();
        bit exp_take;
        ent_t e;
        @(negedge clk);
        exp_take = !m_inflight && pc_valid && (sbq.size() < DEPTH) && !flush;
        chk("pc_take", pc_take, exp_take);
        chk("mem_req", mem_req, m_inflight);
        if (m_inflight) chk("mem_addr", mem_addr, m_addr);
        chk("ins_valid", ins_valid, sbq.size() != 0);
        if (sbq.size() != 0) begin
            chk("ins_out", ins_out, sbq[0].ins);
            chk("ins_pc", ins_pc, sbq[0].pc);
            chk("out_state", out_state, sbq[0].ins[2:0]);
        end else begin
            chk("out_state_idle", out_state, 0);
        end
        if (pc_take) take_cnt++;
        if (mem_req) req_cyc++;
        if (ins_ready && sbq.size() == 0) exp_stall++;
        if (sbq.size() != 0 && ins_ready && !flush) begin
            e = sbq.pop_front();
            pop_cnt++;
            last_pop_pc = e.pc;
        end
        if (flush) sbq.delete();
        if (m_inflight && mem_ack) begin
            if (!m_drop && !flush) begin
                sbq.push_back({mem_rdata, m_addr});
                exp_fetch++;
            end
            m_inflight = 0; m_drop = 0;
        end else if (m_inflight) begin
            if (flush) m_drop = 1;
            m_wait++;
        end
        if (exp_take) begin
            m_inflight = 1; m_addr = pc_in; m_wait = 0;
        end
        took = exp_take;
        @(posedge clk); #1;
        if (auto_ack) begin
            mem_ack   = m_inflight && (m_wait >= ack_lat);
            mem_rdata = m_inflight ? rd_f(m_addr) : 32'hDEAD_0000;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        bit flushed;
        rst = 0; pc_in = 0; pc_valid = 1; flush = 0; mem_ack = 0; mem_rdata = 0;
        ins_ready = 0; auto_ack = 0; ack_lat = 0; take_cnt = 0; req_cyc = 0; pop_cnt = 0;
        last_pop_pc = 0; m_addr = 0; model_reset();

        tv[0] = '{1, 32'h0, 1, 32'h5, 1,  1, 0, 32'h0, 0, 32'h0, 32'h0, 3'd0};
        tv[1] = '{1, 32'h0, 1, 32'h5, 1,  0, 1, 32'h0, 0, 32'h0, 32'h0, 3'd0};
        tv[2] = '{1, 32'h4, 1, 32'h5, 1,  1, 0, 32'h0, 1, 32'h5, 32'h0, 3'd5};
        tv[3] = '{0, 32'h4, 1, 32'h6, 1,  0, 1, 32'h4, 0, 32'h0, 32'h0, 3'd0};
        tv[4] = '{0, 32'h4, 1, 32'h7, 0,  0, 0, 32'h4, 1, 32'h6, 32'h4, 3'd6};
        tv[5] = '{0, 32'h4, 0, 32'h0, 1,  0, 0, 32'h4, 1, 32'h6, 32'h4, 3'd6};
        tv[6] = '{0, 32'h4, 0, 32'h0, 0,  0, 0, 32'h4, 0, 32'h0, 32'h0, 3'd0};

        // Reset state (pc_valid high to show pc_take is held off).
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_take", pc_take, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", ins_valid, 0);
        chk("rst_ins", ins_out, 0);
        chk("rst_pc", ins_pc, 0);
        chk("rst_state", out_state, 0);
        @(posedge clk); #1;
        rst = 1;
        model_reset();

        // Directed vectors: minimum latency, back-to-back fetch, ack while idle.
        for (int i = 0; i < 7; i++) begin
            pc_valid = tv[i].pv; pc_in = tv[i].pc; mem_ack = tv[i].ack;
            mem_rdata = tv[i].rd; ins_ready = tv[i].rdy;
            #3;
            chk($sformatf("v%0d_take", i), pc_take, tv[i].e_take);
            chk($sformatf("v%0d_req", i), mem_req, tv[i].e_req);
            chk($sformatf("v%0d_addr", i), mem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_valid", i), ins_valid, tv[i].e_val);
            chk($sformatf("v%0d_state", i), out_state, tv[i].e_st);
            if (tv[i].e_val) begin
                chk($sformatf("v%0d_ins", i), ins_out, tv[i].e_ins);
                chk($sformatf("v%0d_ipc", i), ins_pc, tv[i].e_pc);
            end
            tick();
        end

        // Fill with ready low: only two pushes, PC 2 waits for space.
        auto_ack = 1; ack_lat = 0; mem_ack = 0; ins_ready = 0;
        pc_valid = 1; pc_in = 0; take_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (took) pc_in = pc_in + 1;
        end
        chk("fill_takes", take_cnt, 2);
        chk("fill_head_pc", ins_pc, 0);
        ins_ready = 1; tick();           // pop PC 0
        ins_ready = 0; tick();           // issue PC 2
        if (took) pc_valid = 0;
        ins_ready = 1; tick();           // ack + pop on the same edge
        chk("pushpop_valid", ins_valid, 1);
        chk("pushpop_pc", ins_pc, 2);
        pc_valid = 0;
        repeat (3) tick();
        chk("order_last_pc", last_pop_pc, 2);

        // Slow memory: request held for four cycles.
        ack_lat = 3; ins_ready = 1; pc_valid = 1; pc_in = 7; req_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (took) pc_valid = 0;
        end
        chk("slow_req_cycles", req_cyc, 4);
        chk("slow_pc", last_pop_pc, 7);

        // Flush in 2nd request cycle with a buffered entry; ack arrives in the 4th.
        ack_lat = 0; ins_ready = 0; pc_valid = 1; pc_in = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (took) pc_valid = 0;
        end
        ack_lat = 3; pc_valid = 1; pc_in = 32'h20; take_cnt = 0; pop_cnt = 0; flushed = 0;
        for (int i = 0; i < 12; i++) begin
            flush = m_inflight && (m_wait == 1) && !flushed;
            if (flush) begin flushed = 1; ins_ready = 1; end
            tick();
            flush = 0;
            if (flushed) pc_in = 32'h10;
            if (took && pc_in == 32'h10) pc_valid = 0;
        end
        chk("flush_takes", take_cnt, 2);
        chk("flush_pops", pop_cnt, 1);
        chk("flush_new_pc", last_pop_pc, 32'h10);

        // Flush coinciding with the ack: data dropped, straight back to idle.
        ack_lat = 1; pc_valid = 1; pc_in = 32'h30; take_cnt = 0; pop_cnt = 0; flushed = 0;
        for (int i = 0; i < 8; i++) begin
            flush = m_inflight && (m_wait == 1) && !flushed;
            if (flush) flushed = 1;
            tick();
            flush = 0;
            if (flushed) pc_in = 32'h50;
            if (took && pc_in == 32'h50) pc_valid = 0;
        end
        chk("flushack_takes", take_cnt, 2);
        chk("flushack_pops", pop_cnt, 1);
        chk("flushack_pc", last_pop_pc, 32'h50);

        // Asynchronous reset in the middle of a request.
        ack_lat = 0; ins_ready = 0; pc_valid = 1; pc_in = 32'h60;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (took) pc_in = 32'h70;
        end
        ack_lat = 20;
        repeat (2) tick();
        #1 rst = 0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_valid", ins_valid, 0);
        chk("arst_state", out_state, 0);
        chk("arst_take", pc_take, 0);
`ifdef FETCH_STATS_EN
        chk("arst_fetch_cnt", fetch_cnt, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
`endif
        #1 rst = 1;
        model_reset();
        mem_ack = 0;
        ack_lat = 0; ins_ready = 1; pc_valid = 1; pc_in = 32'h80; pop_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (took) pc_valid = 0;
        end
        chk("restart_pops", pop_cnt, 1);
        chk("restart_pc", last_pop_pc, 32'h80);
`ifdef FETCH_STATS_EN
        chk("fetch_cnt", fetch_cnt, exp_fetch);
        chk("stall_cnt", stall_cnt, exp_stall);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
